// File: rtl/help_call_monitor.sv
// help_call_monitor: qualifies the asynchronous call_help level, latches an incident, alerts, escalates and counts.
// Latency: 2 cycles of input synchronisation plus 1 state-register cycle; outputs decode registered state/timer.
// Backpressure: none; both inputs are level-sampled every cycle and never stalled.
module help_call_monitor #(
  parameter int unsigned QUAL_CYCLES     = 1_000,
  parameter int unsigned ESCALATE_CYCLES = 25_000_000,
  parameter int unsigned HOLD_CYCLES     = 5_000_000,
  parameter int unsigned BLINK_BIT       = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       call_help_in,
  input  logic       ack_btn,
  output logic       incident_active,
  output logic       operator_buzzer,
  output logic       escalate,
  output logic       ack_led,
  output logic [7:0] incident_count
);

  // Timer is wide enough for the default escalation window; it wraps freely
  // because only equality compares against the terminal counts matter.
  localparam int unsigned TW = 25;

  localparam logic [TW-1:0] QUAL_LAST = TW'(QUAL_CYCLES - 1);
  localparam logic [TW-1:0] ESC_LAST  = TW'(ESCALATE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [4:0]    BLINK_IDX = 5'(BLINK_BIT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_QUALIFY   = 3'd1,
    ST_ALERT     = 3'd2,
    ST_ESCALATED = 3'd3,
    ST_ACKED     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    count_q, count_d;

  // Two-flop synchronisers for both asynchronous inputs, plus an edge register
  // on the acknowledge path so a held button yields one pulse.
  logic call_meta_q, call_s_q;
  logic ack_meta_q, ack_s_q, ack_prev_q;
  logic ack_rise;
  logic qual_done;

  // Synchronise call_help and ack_btn into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      call_meta_q <= 1'b0;
      call_s_q    <= 1'b0;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
      ack_prev_q  <= 1'b0;
    end else begin
      call_meta_q <= call_help_in;
      call_s_q    <= call_meta_q;
      ack_meta_q  <= ack_btn;
      ack_s_q     <= ack_meta_q;
      ack_prev_q  <= ack_s_q;
    end
  end

  assign ack_rise  = ack_s_q & ~ack_prev_q;
  assign qual_done = (state_q == ST_QUALIFY) && call_s_q && (timer_q == QUAL_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack takes priority over the escalation timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (call_s_q) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!call_s_q)      state_d = ST_IDLE;
        else if (qual_done) state_d = ST_ALERT;
      end
      ST_ALERT: begin
        // A dropped call line does not leave ALERT: only an ack clears it.
        if (ack_rise)                state_d = ST_ACKED;
        else if (timer_q == ESC_LAST) state_d = ST_ESCALATED;
      end
      ST_ESCALATED: begin
        if (ack_rise) state_d = ST_ACKED;
      end
      ST_ACKED: begin
        if (!call_s_q && (timer_q == HOLD_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer restarts on every state change and whenever the line is high while acknowledged.
  always_comb begin
    timer_d = timer_q + 1'b1;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == ST_ACKED) && call_s_q) begin
      timer_d = '0;
    end
  end

  // Timer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Incident counter bumps once per qualified incident and saturates at 255.
  always_comb begin
    count_d = count_q;
    if (qual_done && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Incident counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Output decode of registered state and timer.
  always_comb begin
    incident_active = 1'b0;
    operator_buzzer = 1'b0;
    escalate        = 1'b0;
    ack_led         = 1'b0;
    case (state_q)
      ST_ALERT: begin
        incident_active = 1'b1;
        operator_buzzer = ~timer_q[BLINK_IDX];
      end
      ST_ESCALATED: begin
        incident_active = 1'b1;
        operator_buzzer = 1'b1;
        escalate        = 1'b1;
      end
      ST_ACKED: begin
        incident_active = 1'b1;
        ack_led         = 1'b1;
      end
      default: begin
        incident_active = 1'b0;
      end
    endcase
  end

  assign incident_count = count_q;

endmodule
